// File: rtl/conv_image_dma.sv
// -----------------------------------------------------------------------------
// conv_image_dma
//
// Host-side load/unload engine for the image-convolution processor's data RAM.
// A load streams IMG_LEN bytes from the host input stream into data RAM
// starting at IMG_BASE. The processor is then held enabled until it reports
// completion. Finally, OUT_LEN result bytes are read from data RAM starting at
// OUT_BASE and presented one at a time on the host output stream.
//
// The block owns the data-RAM port only while the processor is idle. The
// enclosing level muxes the RAM address, data and enable lines on busy/proc_en.
//
// Ports
//   clk, rst             : single rising-edge clock, asynchronous active-high reset
//   start                : one-cycle pulse, begins a load (accepted in IDLE/DONE)
//   in_valid/in_data     : host input byte stream; in_ready is high in LOAD
//   out_valid/out_data   : host output byte stream, held until out_ready
//   proc_en              : processor enable, high while the processor runs
//   proc_done            : processor completion level, sampled only in RUN
//   ram_addr/ram_w_en/
//   ram_r_en/ram_wdata   : data-RAM port; writes during LOAD, reads during RD
//   ram_rdata            : RAM read data, valid the cycle after ram_r_en
//   busy                 : high from LOAD through HOLD
//   done                 : high in DONE
// -----------------------------------------------------------------------------
module conv_image_dma #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int IMG_BASE = 0,
    parameter int IMG_LEN  = 16,
    parameter int OUT_BASE = 2048,
    parameter int OUT_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              proc_en,
    input  logic              proc_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_w_en,
    output logic              ram_r_en,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RD,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    // One extra counter bit so a full 2^ADDR_W transfer length is representable.
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  IMG_LAST   = CNT_W'(IMG_LEN - 1);
    localparam logic [CNT_W-1:0]  OUT_LAST   = CNT_W'(OUT_LEN - 1);
    localparam logic [ADDR_W-1:0] IMG_BASE_A = ADDR_W'(IMG_BASE);
    localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] cnt_addr;
    logic              accept;

    // Address offsets drop the top counter bit, so base+cnt wraps modulo 2^ADDR_W.
    assign cnt_addr = cnt[ADDR_W-1:0];
    assign accept   = in_ready & in_valid;

    // -------------------------------------------------------------------------
    // Control FSM with registered status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            proc_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from
            // the values that held before this edge, independent of statement order.
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        if (cnt == IMG_LAST) begin
                            state    <= S_RUN;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            proc_en  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                S_RUN: begin
                    if (proc_done) begin
                        state   <= S_RD;
                        proc_en <= 1'b0;
                    end
                end

                // The read is issued combinationally in RD; the data returns in WAIT.
                S_RD: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    out_data  <= ram_rdata;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end

                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cnt == OUT_LAST) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= S_RD;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Data-RAM port: writes follow the input handshake in the same cycle,
    // reads are a single-cycle strobe in RD. Idle port drives all zeros.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        ram_w_en  = 1'b0;
        ram_r_en  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == S_LOAD && accept) begin
            ram_w_en  = 1'b1;
            ram_addr  = IMG_BASE_A + cnt_addr;
            ram_wdata = in_data;
        end else if (state == S_RD) begin
            ram_r_en = 1'b1;
            ram_addr = OUT_BASE_A + cnt_addr;
        end
    end

endmodule

// File: doc/conv_image_dma.md
# conv_image_dma

Host-side load/unload engine for the image-convolution processor's 4096 x 8-bit data RAM. It streams an input image from a host byte interface into data RAM, then holds the processor enabled until it reports completion. It then reads the result region back out of data RAM onto a host output byte stream. It owns the data-RAM port while the processor is idle; the top level muxes RAM address, data and enable lines on `busy`/`proc_en`.

## Interface
- `ADDR_W`, 12, data-RAM address width
- `DATA_W`, 8, pixel width
- `IMG_BASE`, 0, first RAM address of the input image
- `IMG_LEN`, 16, input bytes to load (1..2^ADDR_W)
- `OUT_BASE`, 2048, first RAM address of the result region
- `OUT_LEN`, 4, result bytes to unload (1..2^ADDR_W)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse; begins a load, accepted in IDLE or DONE only
- `in_valid` in 1 / `in_data` in DATA_W / `in_ready` out 1: host input stream
- `out_valid` out 1 / `out_data` out DATA_W / `out_ready` in 1: host output stream
- `proc_en` out 1: drives processor `en`
- `proc_done` in 1: processor completion (`complete`), level
- `ram_addr` out ADDR_W, `ram_w_en` out 1, `ram_r_en` out 1, `ram_wdata` out DATA_W
- `ram_rdata` in DATA_W: RAM read data, valid the cycle after `ram_r_en`
- `busy` out 1: high in LOAD..HOLD
- `done` out 1: high in DONE

## Operation
- States: IDLE, LOAD, RUN, RD, WAIT, HOLD, DONE. One counter `cnt` of ADDR_W+1 bits.
- IDLE/DONE: `start` -> LOAD, `cnt`=0. `start` in any other state is ignored.
- LOAD: `in_ready`=1. On `in_valid&in_ready`, the block drives combinationally in the same cycle `ram_w_en`=1, `ram_addr`=IMG_BASE+cnt and `ram_wdata`=`in_data`, then increments `cnt`. When the accepted byte has cnt==IMG_LEN-1 -> RUN, `cnt`=0.
- RUN: `proc_en`=1 (registered). When `proc_done`=1 is sampled -> RD; `proc_en` falls on that same edge.
- RD: `ram_r_en`=1 and `ram_addr`=OUT_BASE+cnt for one cycle -> WAIT.
- WAIT: `ram_rdata` is registered into `out_data` and `out_valid` set -> HOLD.
- HOLD: `out_valid`=1 and `out_data` stable until `out_ready`. On the handshake: `out_valid` clears; if cnt==OUT_LEN-1 -> DONE, else `cnt`++ -> RD.
- Address arithmetic is modulo 2^ADDR_W: base+cnt wraps past 4095 to 0.
- `ram_w_en` and `ram_r_en` are never high together. Both are 0 outside LOAD/RD.

## Timing
- Reset values: state IDLE, `cnt`=0; `in_ready`, `out_valid`, `proc_en`, `busy`, `done`, `ram_w_en`, `ram_r_en`=0; `out_data`, `ram_addr`, `ram_wdata`=0.
- Load throughput: 1 byte/cycle when `in_valid` is held high. First write occurs in the first LOAD cycle after the `start` edge.
- `proc_en` rises on the cycle after the final input byte is accepted.
- Unload: 3 cycles/byte minimum (RD, WAIT, HOLD) with `out_ready` held high. First `out_valid` appears 2 cycles after `proc_done` is sampled.
- `proc_done` is ignored outside RUN.
- `out_ready` high before `out_valid` has no effect.
- `in_valid` outside LOAD is not accepted, because `in_ready`=0.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. RAM contents already written are kept; a partially delivered output byte is dropped.
- `start` in DONE restarts a load on the next edge and `done` falls on that edge.

## Test plan
- Reset, pulse `start`, stream 16 bytes 0x00..0x0F back-to-back -> RAM writes at addresses 0..15, `proc_en` rises at cycle 17.
- Insert `in_valid` gaps of 2 cycles between bytes -> `in_ready` held high throughout, no duplicate or skipped writes, `cnt` ends at 0 entering RUN.
- RUN with `proc_done` forced at cycle 5, RAM[2048..2051]={0x11,0x22,0x33,0x44}, `out_ready`=1 -> outputs 0x11, 0x22, 0x33, 0x44 at 3-cycle spacing, then `done`=1.
- `out_ready` held low 10 cycles on byte 2 -> `out_valid` and `out_data`=0x33 stable all 10 cycles, no RAM read issued.
- Set IMG_BASE=4094, IMG_LEN=4 -> writes land at 4094, 4095, 0, 1.
- Assert `rst` during the 8th load byte, then `start` again -> IDLE and all outputs 0; the second load starts at IMG_BASE; `start` pulses during RUN are ignored.
